// File: rtl/fft_input_reorder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_input_reorder_pkg                                                |
// | Shared widths, frame length, bank-state encoding and bit reversal.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fft_input_reorder_pkg;

  localparam int DATA_W = 16;
  localparam int LOG2N  = 5;
  localparam int N      = 1 << LOG2N;

  // Lifecycle of one storage bank
  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  // Mirror the LOG2N index bits (MSB <-> LSB)
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_input_reorder_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_input_reorder_bank                                               |
// | One N-entry complex-sample bank: addressed write port, combinational |
// | read port and a 2-bit fill/drain lifecycle state.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fft_input_reorder_bank
  import fft_input_reorder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_last,
  input  logic [LOG2N-1:0]      wr_addr,
  input  logic [2*DATA_W-1:0]   wr_data,
  input  logic                  rd_en,
  input  logic                  rd_last,
  input  logic [LOG2N-1:0]      rd_addr,
  output logic [2*DATA_W-1:0]   rd_data,
  output bank_state_t           state
);

  logic [2*DATA_W-1:0] mem [N];

  // Sample storage; contents need no reset since state gates every read
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

  // Bank lifecycle: first write fills, last write completes, last read frees
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BANK_EMPTY;
    end else begin
      case (state)
        BANK_EMPTY:    if (wr_en) state <= wr_last ? BANK_FULL : BANK_FILLING;
        BANK_FILLING:  if (wr_en && wr_last) state <= BANK_FULL;
        BANK_FULL:     if (rd_en) state <= rd_last ? BANK_EMPTY : BANK_DRAINING;
        BANK_DRAINING: if (rd_en && rd_last) state <= BANK_EMPTY;
        default:       state <= BANK_EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_input_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_input_reorder                                                    |
// | Ping-pong bit-reversal buffer: natural-order frames in, bit-reversed |
// | order out, one sample per cycle each side.                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fft_input_reorder
  import fft_input_reorder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [LOG2N-1:0]  out_idx,
  output logic              out_last
);

  bank_state_t         bank_state   [2];
  logic [2*DATA_W-1:0] bank_rd_data [2];

  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] rd_pos;
  logic [LOG2N-1:0] wr_addr;
  logic             wr_bank;
  logic             rd_bank;
  logic             wr_fire;
  logic             wr_last;
  logic             rd_avail;
  logic             rd_last;
  logic             out_load;

  // Readiness depends only on registered bank state, never on out_ready
  assign in_ready = (bank_state[wr_bank] == BANK_EMPTY) ||
                    (bank_state[wr_bank] == BANK_FILLING);
  assign rd_avail = (bank_state[rd_bank] == BANK_FULL) ||
                    (bank_state[rd_bank] == BANK_DRAINING);

  assign wr_fire  = in_valid & in_ready;
  assign wr_last  = (wr_cnt == LOG2N'(N-1));
  assign rd_last  = (rd_pos == LOG2N'(N-1));
  assign wr_addr  = bitrev(wr_cnt);
  assign out_load = rd_avail & (~out_valid | out_ready);

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_input_reorder_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_fire && (wr_bank == 1'(b))),
        .wr_last (wr_last),
        .wr_addr (wr_addr),
        .wr_data ({in_re, in_im}),
        .rd_en   (out_load && (rd_bank == 1'(b))),
        .rd_last (rd_last),
        .rd_addr (rd_pos),
        .rd_data (bank_rd_data[b]),
        .state   (bank_state[b])
      );
    end
  endgenerate

  // Write/read counters, bank pointers and the registered output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt    <= '0;
      rd_pos    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_last) wr_bank <= ~wr_bank;
      end
      if (out_load) begin
        out_valid        <= 1'b1;
        {out_re, out_im} <= bank_rd_data[rd_bank];
        out_idx          <= bitrev(rd_pos);
        out_last         <= rd_last;
        rd_pos           <= rd_pos + 1'b1;
        if (rd_last) rd_bank <= ~rd_bank;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_input_reorder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_fft_input_reorder                                                 |
// | Directed table vectors plus scoreboard for fft_input_reorder.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fft_input_reorder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_re = '0;
  logic [15:0] in_im = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic [4:0]  out_idx;
  logic        out_last;

  always #5 clk = ~clk;

  fft_input_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  typedef struct {
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic [15:0] exp_re;
    logic [15:0] exp_im;
    logic [4:0]  exp_idx;
    logic        exp_last;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
  } exp_t;

  // Bit-reversed order of 0..31, written out by hand
  int brseq [32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                     1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

  vec_t        tbl [32];
  logic [31:0] fr  [32];
  exp_t        q [$];
  int          mk = 0;
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          first_out_cyc = -1;
  int          last_out_cyc = -1;
  logic        prev_hold = 1'b0;
  logic [37:0] prev_out = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [4:0] brev(input int v);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
    return r;
  endfunction

  // One clock: scoreboard sampling at the falling edge, then return 1ns after the rising edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      mk = 0;
      q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && out_valid)
        check("hold_stable", 64'({out_re, out_im, out_idx, out_last}), 64'(prev_out));
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_re, out_im, out_idx, out_last};
      if (in_valid && in_ready) begin
        fr[mk] = {in_re, in_im};
        if (mk == 31) begin
          for (int p = 0; p < 32; p++) begin
            e.data = fr[brev(p)];
            e.idx  = brev(p);
            e.last = (p == 31);
            q.push_back(e);
          end
        end
        mk = (mk + 1) % 32;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          check("sb_out", 64'({out_re, out_im, out_idx, out_last}), 64'({e.data, e.idx, e.last}));
        end
        n_out++;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_out = 0;
    first_out_cyc = -1;
    last_out_cyc = -1;
  endtask

  task automatic drain(input int bound);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < bound && (q.size() != 0 || out_valid); i++) tick();
  endtask

  initial begin
    int lows, acc, cnt_in, pos;
    logic prev_rdy, seen, got, found;

    for (int k = 0; k < 32; k++) begin
      tbl[k].in_re    = 16'(k);
      tbl[k].in_im    = 16'(-k);
      tbl[k].exp_re   = 16'(brseq[k]);
      tbl[k].exp_im   = 16'(-brseq[k]);
      tbl[k].exp_idx  = 5'(brseq[k]);
      tbl[k].exp_last = (k == 31);
    end

    // ---- reset state and single table-driven frame
    do_reset();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_regs", 64'({out_re, out_im, out_idx, out_last}), 64'(0));
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1;
      in_re = tbl[k].in_re;
      in_im = tbl[k].in_im;
      check("t1_in_ready", 64'(in_ready), 64'(1));
      tick();
    end
    in_valid = 1'b0;
    check("t1_latency_early", 64'(out_valid), 64'(0));
    tick();
    check("t1_latency", 64'(out_valid), 64'(1));
    for (int p = 0; p < 32; p++) begin
      check("t1_vec", 64'({out_valid, out_re, out_im, out_idx, out_last}),
            64'({1'b1, tbl[p].exp_re, tbl[p].exp_im, tbl[p].exp_idx, tbl[p].exp_last}));
      tick();
    end
    check("t1_end_valid", 64'(out_valid), 64'(0));

    // ---- three back-to-back frames at full rate
    do_reset();
    out_ready = 1'b1;
    lows = 0;
    for (int i = 0; i < 96; i++) begin
      in_valid = 1'b1;
      in_re = 16'(i * 3 + 1);
      in_im = ~16'(i);
      if (!in_ready) lows++;
      tick();
    end
    drain(100);
    check("t2_in_ready_lows", 64'(lows), 64'(0));
    check("t2_out_count", 64'(n_out), 64'(96));
    check("t2_contiguous", 64'(last_out_cyc - first_out_cyc), 64'(95));
    check("t2_queue_empty", 64'(q.size()), 64'(0));

    // ---- downstream stalled: both banks fill, then release
    do_reset();
    acc = 0;
    for (int i = 0; i < 80; i++) begin
      in_valid = 1'b1;
      in_re = 16'(i);
      in_im = 16'(100 + i);
      if (in_ready) acc++;
      tick();
    end
    check("t3_accepts", 64'(acc), 64'(64));
    check("t3_in_ready_low", 64'(in_ready), 64'(0));
    check("t3_out_held", 64'({out_valid, out_re}), 64'({1'b1, 16'h0000}));
    in_valid = 1'b0;
    out_ready = 1'b1;
    prev_rdy = in_ready;
    seen = 1'b0;
    for (int i = 0; i < 100 && (q.size() != 0 || out_valid); i++) begin
      tick();
      if (out_valid && out_last && !seen) begin
        check("t3_ready_rise", 64'(in_ready), 64'(1));
        check("t3_ready_before", 64'(prev_rdy), 64'(0));
        seen = 1'b1;
      end
      prev_rdy = in_ready;
    end
    check("t3_seen_last", 64'(seen), 64'(1));
    check("t3_out_count", 64'(n_out), 64'(64));
    check("t3_queue_empty", 64'(q.size()), 64'(0));

    // ---- random valid/ready over ten frames
    do_reset();
    cnt_in = 0;
    for (int i = 0; i < 3000 && cnt_in < 320; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_re = 16'($urandom);
      in_im = 16'($urandom);
      if (in_valid && in_ready) cnt_in++;
      tick();
    end
    drain(200);
    check("t4_in_count", 64'(cnt_in), 64'(320));
    check("t4_out_count", 64'(n_out), 64'(320));
    check("t4_queue_empty", 64'(q.size()), 64'(0));

    // ---- reset while frame 1 drains and frame 2 fills
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 42; i++) begin
      in_valid = 1'b1;
      in_re = 16'(1000 + i);
      in_im = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", 64'(out_valid), 64'(0));
    check("t5_rst_in_ready", 64'(in_ready), 64'(1));
    tick();
    rst = 1'b0;
    n_out = 0;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_re = 16'(500 + i);
      in_im = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60 && (q.size() != 0 || out_valid); i++) begin
      tick();
      if (out_valid && !got) begin
        check("t5_first_sample", 64'({out_re, out_im, out_idx}), 64'({16'd500, 16'd0, 5'd0}));
        got = 1'b1;
      end
    end
    check("t5_got_output", 64'(got), 64'(1));
    check("t5_out_count", 64'(n_out), 64'(32));

    // ---- extreme values at k=1 land at position 16
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1;
      in_re = (k == 1) ? 16'h8000 : 16'(k);
      in_im = (k == 1) ? 16'h7fff : 16'h0000;
      tick();
    end
    in_valid = 1'b0;
    pos = 0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) begin
        if (out_idx == 5'd1) begin
          check("t6_position", 64'(pos), 64'(16));
          check("t6_re", 64'(out_re), 64'(16'h8000));
          check("t6_im", 64'(out_im), 64'(16'h7fff));
          found = 1'b1;
        end
        pos++;
      end
    end
    check("t6_found", 64'(found), 64'(1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
